// File: rtl/banked_burst_mem_pkg.sv
// rtl/banked_burst_mem_pkg.sv - shared types, lane helper and parameter checks
package banked_burst_mem_pkg;

  typedef enum logic [1:0] {IDLE, WRITE, READ, READ_DRAIN} state_t;

  function automatic int nib_lanes(input int data_w);
    return data_w / 4;
  endfunction

  function automatic bit params_legal(input int data_w, input int addr_w,
                                      input int bank_bits, input int burst_len);
    return (data_w > 0) && (data_w % 4 == 0) &&
           (bank_bits >= 1) && (bank_bits < addr_w) &&
           (burst_len >= 2) && (longint'(burst_len) <= (longint'(1) << addr_w));
  endfunction

endpackage

// File: rtl/banked_burst_mem_bank.sv
// rtl/banked_burst_mem_bank.sv - one bank: nibble-strobed synchronous write, registered read
module banked_burst_mem_bank
  import banked_burst_mem_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ROW_W  = 9
) (
  input  logic                         clk,
  input  logic                         en,
  input  logic                         we,
  input  logic [ROW_W-1:0]             row,
  input  logic [DATA_W-1:0]            wdata,
  input  logic [nib_lanes(DATA_W)-1:0] wstrb,
  output logic [DATA_W-1:0]            rdata
);

  localparam int LANES = nib_lanes(DATA_W);

  logic [DATA_W-1:0] mem [2**ROW_W];

  // Array contents are never reset; only the engine state is.
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int i = 0; i < LANES; i++) begin
        if (wstrb[i]) mem[row][i*4 +: 4] <= wdata[i*4 +: 4];
      end
    end
    if (en && !we) rdata <= mem[row];
  end

endmodule

// File: rtl/banked_burst_mem.sv
// rtl/banked_burst_mem.sv - interleaved banked memory with a valid/ready burst engine
module banked_burst_mem
  import banked_burst_mem_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 13,
  parameter int BANK_BITS = 4,
  parameter int BURST_LEN = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [DATA_W-1:0]            wdata,
  input  logic [nib_lanes(DATA_W)-1:0] wstrb,
  input  logic                         wdata_valid,
  output logic                         wdata_ready,
  output logic [DATA_W-1:0]            rdata,
  output logic                         rdata_valid,
  output logic                         done
);

  localparam int NBANKS = 2**BANK_BITS;
  localparam int ROW_W  = ADDR_W - BANK_BITS;
  localparam int CNT_W  = $clog2(BURST_LEN);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  if (!params_legal(DATA_W, ADDR_W, BANK_BITS, BURST_LEN)) begin : g_illegal_params
    $error("banked_burst_mem: illegal parameter combination");
  end

  state_t                state, state_nx;
  logic [ADDR_W-1:0]     cur_addr;
  logic [CNT_W-1:0]      beat_cnt;
  logic                  accept, beat_go, issue_rd, last_beat;
  logic [BANK_BITS-1:0]  bank_sel, sel_d;
  logic [DATA_W-1:0]     bank_q [NBANKS];

  assign last_beat = (beat_cnt == LAST_BEAT);
  assign bank_sel  = cur_addr[BANK_BITS-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // A write burst's done pulse lands in IDLE; holding req_ready low during it
  // keeps the write and read turnaround identical.
  always_comb begin
    state_nx    = state;
    req_ready   = 1'b0;
    wdata_ready = 1'b0;
    accept      = 1'b0;
    beat_go     = 1'b0;
    issue_rd    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !done;
        accept    = req_valid && !done;
        if (accept) state_nx = req_write ? WRITE : READ;
      end
      WRITE: begin
        wdata_ready = 1'b1;
        beat_go     = wdata_valid;
        if (wdata_valid && last_beat) state_nx = IDLE;
      end
      READ: begin
        beat_go  = 1'b1;
        issue_rd = 1'b1;
        if (last_beat) state_nx = READ_DRAIN;
      end
      READ_DRAIN: state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_addr    <= '0;
      beat_cnt    <= '0;
      rdata_valid <= 1'b0;
      done        <= 1'b0;
      sel_d       <= '0;
    end else begin
      rdata_valid <= issue_rd;
      done        <= beat_go && last_beat;
      if (issue_rd) sel_d <= bank_sel;
      if (accept) begin
        cur_addr <= req_addr;
        beat_cnt <= '0;
      end else if (beat_go) begin
        cur_addr <= cur_addr + ADDR_W'(1);
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
    end
  end

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    logic en;
    assign en = beat_go && (bank_sel == BANK_BITS'(b));
    banked_burst_mem_bank #(
      .DATA_W (DATA_W),
      .ROW_W  (ROW_W)
    ) u_bank (
      .clk   (clk),
      .en    (en),
      .we    (state == WRITE),
      .row   (cur_addr[ADDR_W-1:BANK_BITS]),
      .wdata (wdata),
      .wstrb (wstrb),
      .rdata (bank_q[b])
    );
  end

  assign rdata = rdata_valid ? bank_q[sel_d] : '0;

endmodule

// File: tb/tb_banked_burst_mem.sv
// tb/tb_banked_burst_mem.sv - directed self-checking bench for banked_burst_mem
module tb_banked_burst_mem;

  localparam int DW = 64;
  localparam int AW = 13;
  localparam int LW = DW / 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [LW-1:0] wstrb = '0;
  logic          wdata_valid = 1'b0;
  logic          wdata_ready;
  logic [DW-1:0] rdata;
  logic          rdata_valid;
  logic          done;

  int n_assert = 0;
  int n_fail   = 0;

  logic [DW-1:0] wd [8];
  logic [LW-1:0] ws [8];
  logic [DW-1:0] rd_cap [8];
  logic [DW-1:0] model [int];

  banked_burst_mem dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .wdata       (wdata),
    .wstrb       (wstrb),
    .wdata_valid (wdata_valid),
    .wdata_ready (wdata_ready),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .done        (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic wr, input logic [AW-1:0] a);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    while (req_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("req_ready_before_accept", req_ready, 1);
    tick();
    req_valid = 1'b0;
    chk("req_ready_after_accept", req_ready, 0);
  endtask

  task automatic write_burst(input logic [AW-1:0] a, input bit stall);
    logic [AW-1:0] ad;
    request(1'b1, a);
    for (int k = 0; k < 8; k++) begin
      wdata_valid = 1'b1;
      wdata       = wd[k];
      wstrb       = ws[k];
      chk("wdata_ready_beat", wdata_ready, 1);
      chk("no_early_done_wr", done, 0);
      tick();
      ad = a + AW'(k);
      for (int i = 0; i < LW; i++)
        if (ws[k][i]) model[int'(ad)][i*4 +: 4] = wd[k][i*4 +: 4];
      if (stall && k < 7) begin
        wdata_valid = 1'b0;
        wdata       = '1;
        wstrb       = '1;
        chk("wdata_ready_stall", wdata_ready, 1);
        tick();
      end
    end
    wdata_valid = 1'b0;
    chk("wr_done_pulse", done, 1);
    chk("wr_ready_during_done", req_ready, 0);
    chk("wr_wdata_ready_off", wdata_ready, 0);
    tick();
    chk("wr_done_single", done, 0);
    chk("wr_ready_back", req_ready, 1);
  endtask

  task automatic read_beats(input logic [AW-1:0] a);
    logic [AW-1:0] ad;
    chk("rd_no_valid_issue_cycle", rdata_valid, 0);
    tick();
    for (int k = 0; k < 8; k++) begin
      ad = a + AW'(k);
      chk("rd_valid", rdata_valid, 1);
      chk("rd_data", rdata, model[int'(ad)]);
      chk("rd_done", done, (k == 7) ? 1 : 0);
      rd_cap[k] = rdata;
      tick();
    end
    chk("rd_valid_end", rdata_valid, 0);
    chk("rd_ready_back", req_ready, 1);
  endtask

  task automatic read_burst(input logic [AW-1:0] a);
    request(1'b0, a);
    read_beats(a);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_req_ready", req_ready, 1);
    chk("reset_wdata_ready", wdata_ready, 0);
    chk("reset_rdata", rdata, 0);
    chk("reset_rdata_valid", rdata_valid, 0);
    chk("reset_done", done, 0);
    rst = 1'b0;
    tick();

    // Basic burst at 0
    for (int k = 0; k < 8; k++) begin
      wd[k] = 64'h1111_1111_1111_1111 * (k + 1);
      ws[k] = '1;
    end
    write_burst(13'h0000, 1'b0);
    read_burst(13'h0000);
    chk("basic_beat0", rd_cap[0], 64'h1111_1111_1111_1111);
    chk("basic_beat7", rd_cap[7], 64'h8888_8888_8888_8888);

    // Address wrap across the top of the space
    for (int k = 0; k < 8; k++) begin
      wd[k] = 64'hA5A5_0000_0000_0000 + 64'(k);
      ws[k] = '1;
    end
    write_burst(13'h1FFE, 1'b0);
    read_burst(13'h1FFE);
    chk("wrap_beat1", rd_cap[1], 64'hA5A5_0000_0000_0001);
    read_burst(13'h0000);
    chk("wrap_landed_at_0", rd_cap[0], 64'hA5A5_0000_0000_0002);
    chk("wrap_landed_at_5", rd_cap[5], 64'hA5A5_0000_0000_0007);
    chk("wrap_untouched_6", rd_cap[6], 64'h7777_7777_7777_7777);

    // Nibble strobes
    for (int k = 0; k < 8; k++) begin
      wd[k] = 64'hFFFF_FFFF_FFFF_FFFF;
      ws[k] = '1;
    end
    write_burst(13'h0005, 1'b0);
    for (int k = 0; k < 8; k++) begin
      wd[k] = '0;
      ws[k] = '0;
    end
    ws[0] = 16'h000F;
    write_burst(13'h0005, 1'b0);
    read_burst(13'h0005);
    chk("strobe_addr5", rd_cap[0], 64'hFFFF_FFFF_FFFF_0000);
    chk("strobe_zero_addr6", rd_cap[1], 64'hFFFF_FFFF_FFFF_FFFF);

    // Write stalls on alternate cycles
    for (int k = 0; k < 8; k++) begin
      wd[k] = 64'h0100_0000_0000_0000 + 64'(k * 3);
      ws[k] = '1;
    end
    write_burst(13'h0100, 1'b1);
    read_burst(13'h0100);
    chk("stall_beat7", rd_cap[7], 64'h0100_0000_0000_0015);

    // Busy rejection with req_valid held through a read burst
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 13'h0100;
    chk("busy_ready_c0", req_ready, 1);
    tick();
    for (int c = 1; c <= 9; c++) begin
      chk("busy_ready_low", req_ready, 0);
      if (c >= 2) chk("busy_rdata", rdata, model[int'(13'h0100 + 13'(c - 2))]);
      tick();
    end
    chk("busy_ready_c10", req_ready, 1);
    tick();
    req_valid = 1'b0;
    read_beats(13'h0100);

    // Mid-burst reset
    for (int k = 0; k < 8; k++) begin
      wd[k] = 64'hBBBB_0000_0000_0000 + 64'(k);
      ws[k] = '1;
    end
    write_burst(13'h0200, 1'b0);
    request(1'b1, 13'h0200);
    for (int k = 0; k < 3; k++) begin
      wdata_valid = 1'b1;
      wdata       = 64'hCCCC_0000_0000_0000 + 64'(k);
      wstrb       = '1;
      tick();
      model[int'(13'h0200 + 13'(k))] = 64'hCCCC_0000_0000_0000 + 64'(k);
    end
    rst = 1'b1;
    #1;
    chk("midrst_req_ready", req_ready, 1);
    chk("midrst_wdata_ready", wdata_ready, 0);
    chk("midrst_done", done, 0);
    chk("midrst_rdata_valid", rdata_valid, 0);
    chk("midrst_rdata", rdata, 0);
    wdata_valid = 1'b0;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("midrst_no_done", done, 0);
      tick();
    end
    read_burst(13'h0200);
    chk("midrst_beat2_written", rd_cap[2], 64'hCCCC_0000_0000_0002);
    chk("midrst_beat3_kept", rd_cap[3], 64'hBBBB_0000_0000_0003);
    chk("midrst_beat7_kept", rd_cap[7], 64'hBBBB_0000_0000_0007);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/banked_burst_mem.md
# banked_burst_mem

Parametrised banked memory with an address-incrementing burst engine and a valid/ready request interface. It is the next-generation replacement for the fixed 16-chip, 8-beat DRAM model. Width, depth, bank count and burst length are now configurable, and it adds:
- a request handshake;
- per-nibble write strobes;
- read data with a beat-valid qualifier;
- a burst-done pulse.

It sits between the test CPU/load-store path and the memory array.

## Interface
Parameters:
- DATA_W, 64, data width in bits; must be a multiple of 4.
- ADDR_W, 13, word address width; total depth is 2^ADDR_W words.
- BANK_BITS, 4, log2 of the bank count; must be less than ADDR_W.
- BURST_LEN, 8, beats per burst; must be 2 or more and no greater than 2^ADDR_W.

Ports:
- clk  in  1  the single clock; all state is updated on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  a burst request is presented.
- req_ready  out  1  the block can accept a request; high only in IDLE.
- req_write  in  1  1 = write burst, 0 = read burst; sampled on the request handshake.
- req_addr  in  ADDR_W  start word address; sampled on the request handshake.
- wdata  in  DATA_W  write beat data.
- wstrb  in  DATA_W/4  per-nibble write enables.
- wdata_valid  in  1  a write beat is presented.
- wdata_ready  out  1  a write beat is accepted; high only in WRITE.
- rdata  out  DATA_W  read beat data.
- rdata_valid  out  1  rdata carries a valid beat.
- done  out  1  one-cycle pulse when a burst completes.

## Operation
- Bank mapping is interleaved:
  - bank index = addr[BANK_BITS-1:0];
  - row within the bank = addr[ADDR_W-1:BANK_BITS].
- Each bank holds 2^(ADDR_W-BANK_BITS) words.
- Exactly one bank is enabled per beat.
- State machine states are IDLE, WRITE, READ and READ_DRAIN.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready, latch req_addr into cur_addr and clear beat_cnt.
  - Go to WRITE if req_write = 1, otherwise go to READ.
- WRITE:
  - wdata_ready = 1.
  - Each cycle with wdata_valid = 1 writes the nibbles of wdata selected by wstrb to mem[cur_addr], then does cur_addr+1 and beat_cnt+1.
  - Cycles with wdata_valid = 0 are stalls and change nothing.
  - After beat BURST_LEN-1 is accepted, pulse done and go to IDLE.
- READ:
  - Issues one read per cycle with no stalls, reading mem[cur_addr] and then doing cur_addr+1.
  - After issuing beat BURST_LEN-1, go to READ_DRAIN.
- READ_DRAIN:
  - The last beat is returned.
  - done pulses in the same cycle as the last rdata_valid.
  - Go to IDLE.
- cur_addr wraps modulo 2^ADDR_W, e.g. 2^ADDR_W-1 is followed by 0. The wrap crosses banks normally.
- wstrb = 0 on a valid beat counts as a beat but changes no memory.
- Requests presented while busy are not accepted. The requester holds req_valid until it sees req_ready.
- Reset:
  - rst forces IDLE and clears cur_addr, beat_cnt, rdata, rdata_valid and done to 0.
  - Memory contents are not cleared. Contents before the first write are undefined to the bench.
  - An asserted reset mid-burst aborts the burst. Beats already written stay written, and no done pulse is produced.

## Timing
- Request handshake to the first write opportunity: 1 cycle. wdata_ready is high in the cycle after acceptance.
- Read latency is 1 cycle, with registered bank output:
  - beat k issued in cycle t produces rdata_valid = 1 in cycle t+1;
  - rdata_valid is asserted for exactly BURST_LEN consecutive cycles.
- Read burst: the request is accepted in cycle 0, the first rdata_valid is in cycle 2, and done is in cycle BURST_LEN+1. req_ready rises again in cycle BURST_LEN+2.
- Write burst with no stalls: done is in the cycle after the final accepted beat. req_ready is high in the cycle after that.
- Read-after-write to the same address in back-to-back bursts returns the new data, since the write completes before IDLE.
- Reset values of all outputs:
  - req_ready = 1;
  - wdata_ready = 0;
  - rdata = 0;
  - rdata_valid = 0;
  - done = 0.

## Structure
- A shared package holds:
  - the state enum (IDLE, WRITE, READ, READ_DRAIN);
  - the function for the nibble-lane count (DATA_W/4);
  - the parameter legality checks.
- Sub-module banked_burst_mem_bank: one bank with a synchronous write, per-nibble strobes and a registered read. It is instantiated 2^BANK_BITS times under a generate loop.
- Read data selection uses a one-cycle-delayed copy of the bank index to mux the registered bank outputs. There are no tri-state buses.

## Test plan
- Reset, then a write burst at address 0x0000 of 8 beats with data 0x1111…×(k+1) and wstrb all ones, then a read burst at 0x0000 → 8 rdata_valid beats in order, matching the written data, with done on the 8th.
- Wrap: write at 0x1FFE (ADDR_W = 13) → beats land at 0x1FFE, 0x1FFF, then 0x0000 to 0x0005. Reading back from 0x1FFE matches.
- Strobes: write 0xFFFF_FFFF_FFFF_FFFF to address 5, then a second burst writes 0x0 with wstrb = 0x000F → a read of address 5 returns 0xFFFF_FFFF_FFFF_0000.
- Write stalls: wdata_valid toggling 1,0,1,0… → exactly 8 beats are written to consecutive addresses, and done comes 1 cycle after the 8th accepted beat.
- Busy rejection: req_valid is held high during a read burst → req_ready stays 0 until cycle BURST_LEN+2, and the second request is accepted then.
- Mid-burst reset: rst is pulsed after 3 of 8 write beats → outputs go to their reset values immediately, no done pulse occurs, and a readback shows beats 0 to 2 written while addresses 3 to 7 are unchanged.
